mem_arbiter: RTL and testbench

Two-requester arbiter that lets the instruction-fetch port and the execute-stage data port share one single-ported synchronous memory. Grants one access per cycle (data normally wins, with a starvation guard for fetch), forwards the winner's command to the memory, and routes read data back to the owning requester after the memory's fixed read latency. Sits between the core (fetch and execute) and the instruction/data memory model.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/resp_tag_pipe.sv | 42 ++++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and bounds for the fetch/data memory arbiter.
// Tags identify which requester owns a read that is still in flight.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_D    = 2'd2
    } tag_t;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;
    localparam int MAX_STREAK_MIN   = 1;
    localparam int MAX_STREAK_MAX   = 15;
    localparam int STREAK_W         = 4;

endpackage

// File: rtl/resp_tag_pipe.sv
// Shift register of requester tags that mirrors the memory read latency,
// so the head entry names the owner of the data currently on mem_rdata.
module resp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clear_i,
    input  tag_t tag_i,
    output tag_t head_o,
    output logic busy_o
);

    tag_t tag_q [DEPTH];

    // Clearing drops every outstanding read so no stale response escapes.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign head_o = tag_q[DEPTH-1];

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tag_q[i] != TAG_NONE) begin
                busy_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and
// the execute-stage data port; data wins unless fetch has waited too long.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_STREAK   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Out-of-range parameters saturate to the nearest legal value.
    localparam int PIPE_DEPTH =
        (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
        (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;
    localparam int STREAK_LIM =
        (MAX_STREAK < MAX_STREAK_MIN) ? MAX_STREAK_MIN :
        (MAX_STREAK > MAX_STREAK_MAX) ? MAX_STREAK_MAX : MAX_STREAK;
    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(STREAK_LIM);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    tag_t                push_tag;
    tag_t                head_tag;
    logic                pipe_busy;

    // Data normally wins; once fetch has watched STREAK_CAP data grants go by,
    // fetch takes the next slot.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (d_req && (!if_req || streak_q != STREAK_CAP)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (d_gnt && streak_q != STREAK_CAP) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        push_tag  = TAG_NONE;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            push_tag  = d_we ? TAG_NONE : TAG_D;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            push_tag = TAG_IF;
        end
    end

    resp_tag_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_tag_pipe (
        .clk     (clk),
        .clear_i (rst),
        .tag_i   (push_tag),
        .head_o  (head_tag),
        .busy_o  (pipe_busy)
    );

    // The pipe only clears at the end of a reset cycle, so responses are
    // also masked while rst is high.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        if (!rst) begin
            case (head_tag)
                TAG_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                TAG_D: begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign busy = pipe_busy & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a requester-level reference model predicts
// grants and read data, and a separate monitor checks responses from a queue.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int MS = 4;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (RL),
        .MAX_STREAK   (MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            isD;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dreq_t;

    resp_t         expQ[$];
    logic [AW-1:0] ifScript[$];
    dreq_t         dScript[$];

    int vecCount  = 0;
    int missCount = 0;
    int cyc       = 0;

    bit            ifPend;
    logic [AW-1:0] ifAddr;
    bit            dPend;
    bit            dWe;
    logic [AW-1:0] dAddr;
    logic [DW-1:0] dWdata;
    int            waitCnt;
    int            ifPct;
    int            dPct;

    logic [DW-1:0] envMem [1024];
    logic [DW-1:0] refMem [1024];
    logic [DW-1:0] rdPipe [RL];

    function automatic logic [DW-1:0] memInit(input int idx);
        return (DW'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory environment: fixed-latency synchronous RAM, garbage on idle cycles.
    assign mem_rdata = rdPipe[RL-1];
    always @(posedge clk) begin
        for (int i = 1; i < RL; i++) rdPipe[i] <= rdPipe[i-1];
        if (mem_en && !mem_we) rdPipe[0] <= envMem[mem_addr[11:2]];
        else                   rdPipe[0] <= $urandom;
        if (mem_en && mem_we) envMem[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of requests; a requester holds its request until granted.
    task automatic applyStimulus(input bit doReset);
        @(posedge clk);
        #1;
        rst = doReset;
        if (doReset) begin
            expQ.delete();
            waitCnt = 0;
        end
        if (!ifPend) begin
            if (ifScript.size() > 0) begin
                ifAddr = ifScript.pop_front();
                ifPend = 1'b1;
            end else if ($urandom_range(99) < ifPct) begin
                ifAddr = AW'($urandom_range(1023)) << 2;
                ifPend = 1'b1;
            end
        end
        if (!dPend) begin
            if (dScript.size() > 0) begin
                dreq_t s;
                s      = dScript.pop_front();
                dWe    = s.we;
                dAddr  = s.addr;
                dWdata = s.wdata;
                dPend  = 1'b1;
            end else if ($urandom_range(99) < dPct) begin
                dWe    = ($urandom_range(2) == 0);
                dAddr  = AW'($urandom_range(1023)) << 2;
                dWdata = $urandom;
                dPend  = 1'b1;
            end
        end
        if_req  = ifPend;
        if_addr = ifPend ? ifAddr : AW'($urandom);
        d_req   = dPend;
        d_we    = dPend ? dWe : 1'($urandom);
        d_addr  = dPend ? dAddr : AW'($urandom);
        d_wdata = dPend ? dWdata : DW'($urandom);
    endtask

    // Predict the grant from the priority rules, check the command, queue reads.
    task automatic checkOutput();
        bit            expIf;
        bit            expD;
        bit            expEn;
        bit            expWe;
        bit            ifWasPend;
        logic [AW-1:0] expAddr;
        @(negedge clk);
        expIf = 1'b0;
        expD  = 1'b0;
        if (!rst) begin
            if (dPend && (!ifPend || waitCnt != MS)) expD = 1'b1;
            else if (ifPend)                         expIf = 1'b1;
        end
        expEn   = expIf | expD;
        expWe   = expD & dWe;
        expAddr = expD ? dAddr : (expIf ? ifAddr : '0);
        checkVal("if_gnt", 64'(if_gnt), 64'(expIf));
        checkVal("d_gnt", 64'(d_gnt), 64'(expD));
        checkVal("mem_en", 64'(mem_en), 64'(expEn));
        checkVal("mem_we", 64'(mem_we), 64'(expWe));
        checkVal("mem_addr", 64'(mem_addr), 64'(expAddr));
        if (expWe)       checkVal("mem_wdata", 64'(mem_wdata), 64'(dWdata));
        else if (!expEn) checkVal("mem_wdata_idle", 64'(mem_wdata), 64'(0));

        ifWasPend = ifPend;
        if (expD) begin
            if (dWe) refMem[dAddr[11:2]] = dWdata;
            else     expQ.push_back('{isD: 1'b1, data: refMem[dAddr[11:2]], due: cyc + RL});
            dPend = 1'b0;
        end
        if (expIf) begin
            expQ.push_back('{isD: 1'b0, data: refMem[ifAddr[11:2]], due: cyc + RL});
            ifPend = 1'b0;
        end
        if (rst || !ifWasPend || expIf) waitCnt = 0;
        else if (expD)                  waitCnt = waitCnt + 1;
    endtask

    task automatic runCycle(input bit doReset);
        applyStimulus(doReset);
        checkOutput();
    endtask

    // Response monitor: pops the scoreboard whenever a port presents rvalid.
    always @(negedge clk) begin
        resp_t r;
        bit    expBusy;
        expBusy = 1'b0;
        foreach (expQ[i]) if (expQ[i].due - RL < cyc) expBusy = 1'b1;
        checkVal("busy", 64'(busy), 64'(expBusy));
        checkVal("rvalid_exclusive", 64'(if_rvalid & d_rvalid), 64'(0));
        if (if_rvalid || d_rvalid) begin
            vecCount++;
            if (expQ.size() == 0) begin
                missCount++;
                $display("[TB] FAIL unexpected_rvalid: got if=%0b d=%0b, expected none (cycle %0d)",
                         if_rvalid, d_rvalid, cyc);
            end else begin
                r = expQ.pop_front();
                checkVal("rvalid_port_is_d", 64'(d_rvalid), 64'(r.isD));
                checkVal("rvalid_cycle", 64'(cyc), 64'(r.due));
                checkVal("rdata", 64'(r.isD ? d_rdata : if_rdata), 64'(r.data));
            end
        end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
            vecCount++;
            missCount++;
            r = expQ.pop_front();
            $display("[TB] FAIL missing_rvalid: got none, expected %s data 0x%0h (cycle %0d)",
                     r.isD ? "d" : "if", r.data, cyc);
        end
        if (!if_rvalid) checkVal("if_rdata_idle", 64'(if_rdata), 64'(0));
        if (!d_rvalid)  checkVal("d_rdata_idle", 64'(d_rdata), 64'(0));
    end

    initial begin
        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        ifPend  = 1'b0;
        dPend   = 1'b0;
        waitCnt = 0;
        ifPct   = 0;
        dPct    = 0;
        for (int i = 0; i < 1024; i++) begin
            envMem[i] = memInit(i);
            refMem[i] = memInit(i);
        end

        // Requests held through reset: no grants until release, then data wins.
        ifPend = 1'b1; ifAddr = 32'h300;
        dPend  = 1'b1; dWe = 1'b0; dAddr = 32'h304; dWdata = '0;
        for (int i = 0; i < 3; i++) runCycle(1'b1);
        for (int i = 0; i < 6; i++) runCycle(1'b0);

        // Back-to-back fetches.
        ifScript.push_back(32'h10);
        ifScript.push_back(32'h14);
        ifScript.push_back(32'h18);
        for (int i = 0; i < 3 + RL + 2; i++) runCycle(1'b0);

        // Write followed by a read of the same word.
        dScript.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEAD_BEEF});
        dScript.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        for (int i = 0; i < 2 + RL + 2; i++) runCycle(1'b0);

        // Alternating fetch and data reads.
        for (int i = 0; i < 8; i++) begin
            ifScript.push_back(32'h0);
            runCycle(1'b0);
            dScript.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
            runCycle(1'b0);
        end
        for (int i = 0; i < RL + 2; i++) runCycle(1'b0);

        // Continuous contention exercises the fetch starvation guard.
        ifPct = 100;
        dPct  = 100;
        for (int i = 0; i < 30; i++) runCycle(1'b0);
        ifPct = 0;
        dPct  = 0;
        for (int i = 0; i < RL + 4; i++) runCycle(1'b0);

        // Reset lands while two reads are in flight.
        dScript.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
        ifScript.push_back(32'h204);
        runCycle(1'b0);
        runCycle(1'b0);
        runCycle(1'b1);
        for (int i = 0; i < RL + 2; i++) runCycle(1'b0);
        ifScript.push_back(32'h208);
        for (int i = 0; i < RL + 2; i++) runCycle(1'b0);

        // Random traffic with occasional resets.
        ifPct = 60;
        dPct  = 60;
        for (int i = 0; i < 400; i++) runCycle($urandom_range(99) < 2);
        ifPct = 0;
        dPct  = 0;
        for (int i = 0; i < RL + 6; i++) runCycle(1'b0);

        checkVal("drain_empty", 64'(expQ.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
